// File: rtl/control_topos.sv
// -----------------------------------------------------------------------------
// control_topos
// Game controller for the whack-a-mole grid. It picks the mole positions, drives
// one place-mole line per cell, moves the one-hot selection cursor, broadcasts
// the strike pulse and turns the per-cell HIT returns into score and misses.
//
// Ports
//   Clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   iSTART       in   one-cycle pulse; starts or restarts a game
//   iBTN_NEXT    in   one-cycle pulse; cursor +1 (wraps)
//   iBTN_PREV    in   one-cycle pulse; cursor -1 (wraps)
//   iBTN_HIT     in   one-cycle pulse; player strike
//   iHIT         in   [N_CELLS] per-cell hit return
//   oPONER_TOPO  out  [N_CELLS] one-hot mole placement, zero when no mole is up
//   oSELECT      out  [N_CELLS] one-hot cursor
//   oGOLPE       out  strike pulse broadcast to all cells
//   oSCORE       out  [8] hits this game, saturating at 255
//   oMISSES      out  [8] expired moles this game
//   oGAME_OVER   out  high while the game is over
// -----------------------------------------------------------------------------
module control_topos #(
   parameter int N_CELLS    = 9,
   parameter int TICK_DIV   = 25000000,
   parameter int MOLE_TICKS = 3,
   parameter int GAP_TICKS  = 2,
   parameter int MAX_MISSES = 5
) (
   input  logic               Clock,
   input  logic               reset,
   input  logic               iSTART,
   input  logic               iBTN_NEXT,
   input  logic               iBTN_PREV,
   input  logic               iBTN_HIT,
   input  logic [N_CELLS-1:0] iHIT,
   output logic [N_CELLS-1:0] oPONER_TOPO,
   output logic [N_CELLS-1:0] oSELECT,
   output logic               oGOLPE,
   output logic [7:0]         oSCORE,
   output logic [7:0]         oMISSES,
   output logic               oGAME_OVER
);

   localparam int IDX_W  = $clog2(N_CELLS);
   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int LIFE_W = $clog2(MOLE_TICKS + 1);
   localparam int GAPC_W = $clog2(GAP_TICKS + 1);

   localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CELLS - 1);
   localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [LIFE_W-1:0] LIFE_ZERO = {LIFE_W{1'b0}};
   localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(1);
   localparam logic [LIFE_W-1:0] LIFE_LOAD = LIFE_W'(MOLE_TICKS);
   localparam logic [GAPC_W-1:0] GAP_ZERO  = {GAPC_W{1'b0}};
   localparam logic [GAPC_W-1:0] GAP_ONE   = GAPC_W'(1);
   localparam logic [GAPC_W-1:0] GAP_LOAD  = GAPC_W'(GAP_TICKS);
   localparam logic [7:0]        MISS_LIM  = 8'(MAX_MISSES);
   localparam logic [7:0]        LFSR_MOD  = 8'(N_CELLS);
   localparam logic [7:0]        LFSR_SEED = 8'hA5;
   localparam logic [N_CELLS-1:0] CELLS_ZERO = {N_CELLS{1'b0}};
   localparam logic [N_CELLS-1:0] CELL0_HOT  = {{(N_CELLS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SPAWN = 3'd1,
      S_UP    = 3'd2,
      S_GAP   = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   // One-hot decode of a cell index.
   function automatic logic [N_CELLS-1:0] f_onehot(input logic [IDX_W-1:0] idx);
      return CELL0_HOT << idx;
   endfunction

   // Fibonacci LFSR step, taps 8,6,5,4 (a maximal-length polynomial, so a
   // non-zero seed never reaches the all-zero lock-up state).
   function automatic logic [7:0] f_lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_lfsr;
   logic [IDX_W-1:0]    r_cur_idx;
   logic [IDX_W-1:0]    w_cur_nxt;
   logic [N_CELLS-1:0]  r_select;
   logic                r_golpe;
   logic [DIV_W-1:0]    r_div;
   logic                w_tick;
   logic [LIFE_W-1:0]   r_life;
   logic                w_expire;
   logic [GAPC_W-1:0]   r_gap_cnt;
   logic                w_gap_done;
   logic [IDX_W-1:0]    r_mole_idx;
   logic [IDX_W-1:0]    w_cand;
   logic [IDX_W-1:0]    w_pick;
   logic [N_CELLS-1:0]  r_poner;
   logic                w_hit;
   logic                w_start_game;
   logic [7:0]          r_score;
   logic [7:0]          r_misses;
   logic                r_game_over;

   assign w_tick       = (r_div == DIV_LAST);
   assign w_expire     = w_tick && (r_life == LIFE_ONE);
   assign w_gap_done   = w_tick && (r_gap_cnt == GAP_ONE);
   // r_poner is only non-zero in UP and then holds exactly the mole's bit, so
   // masking iHIT with it ignores returns from every other cell.
   assign w_hit        = |(iHIT & r_poner);
   assign w_start_game = iSTART && ((r_state == S_IDLE) || (r_state == S_OVER));

   // Mole candidate from the LFSR, nudged by one when it repeats the last mole.
   always_comb begin
      w_cand = IDX_W'(r_lfsr % LFSR_MOD);
      if (w_cand != r_mole_idx) begin
         w_pick = w_cand;
      end else if (w_cand == IDX_LAST) begin
         w_pick = IDX_ZERO;
      end else begin
         w_pick = w_cand + IDX_ONE;
      end
   end

   // Cursor next index; simultaneous NEXT and PREV cancel out.
   always_comb begin
      w_cur_nxt = r_cur_idx;
      if (iBTN_NEXT && !iBTN_PREV) begin
         w_cur_nxt = (r_cur_idx == IDX_LAST) ? IDX_ZERO : (r_cur_idx + IDX_ONE);
      end else if (iBTN_PREV && !iBTN_NEXT) begin
         w_cur_nxt = (r_cur_idx == IDX_ZERO) ? IDX_LAST : (r_cur_idx - IDX_ONE);
      end else begin
         w_cur_nxt = r_cur_idx;
      end
   end

   // Game FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (iSTART) begin
               w_state_nxt = S_SPAWN;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_SPAWN: begin
            w_state_nxt = S_UP;
         end
         S_UP: begin
            // A hit and an expiry on the same edge both leave for GAP; the
            // counter block gives the hit priority.
            if (w_hit || w_expire) begin
               w_state_nxt = S_GAP;
            end else begin
               w_state_nxt = S_UP;
            end
         end
         S_GAP: begin
            if (w_gap_done) begin
               if (r_misses >= MISS_LIM) begin
                  w_state_nxt = S_OVER;
               end else begin
                  w_state_nxt = S_SPAWN;
               end
            end else begin
               w_state_nxt = S_GAP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register and free-running LFSR.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_lfsr  <= LFSR_SEED;
      end else begin
         r_state <= w_state_nxt;
         r_lfsr  <= f_lfsr_step(r_lfsr);
      end
   end

   // Cursor index and its registered one-hot form, active in every state.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_cur_idx <= IDX_ZERO;
         r_select  <= CELL0_HOT;
      end else begin
         r_cur_idx <= w_cur_nxt;
         r_select  <= f_onehot(w_cur_nxt);
      end
   end

   // Strike pulse, only honoured while a mole is up.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_golpe <= 1'b0;
      end else begin
         r_golpe <= iBTN_HIT && (r_state == S_UP);
      end
   end

   // Tick divider; restarts on every state change so UP and GAP start on a
   // fresh tick period.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_div <= DIV_ZERO;
      end else if (w_state_nxt != r_state) begin
         r_div <= DIV_ZERO;
      end else if (w_tick) begin
         r_div <= DIV_ZERO;
      end else begin
         r_div <= r_div + DIV_ONE;
      end
   end

   // Mole life counter: loaded in SPAWN, one step down per tick in UP.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_life <= LIFE_ZERO;
      end else if (r_state == S_SPAWN) begin
         r_life <= LIFE_LOAD;
      end else if ((r_state == S_UP) && w_tick) begin
         r_life <= r_life - LIFE_ONE;
      end else begin
         r_life <= r_life;
      end
   end

   // Gap counter: loaded when leaving UP, one step down per tick in GAP.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_gap_cnt <= GAP_ZERO;
      end else if ((r_state == S_UP) && (w_state_nxt == S_GAP)) begin
         r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == S_GAP) && w_tick) begin
         r_gap_cnt <= r_gap_cnt - GAP_ONE;
      end else begin
         r_gap_cnt <= r_gap_cnt;
      end
   end

   // Mole index latch and placement lines; the index doubles as "previous mole".
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_mole_idx <= IDX_ZERO;
         r_poner    <= CELLS_ZERO;
      end else if (r_state == S_SPAWN) begin
         r_mole_idx <= w_pick;
         r_poner    <= f_onehot(w_pick);
      end else if (w_state_nxt != S_UP) begin
         r_mole_idx <= r_mole_idx;
         r_poner    <= CELLS_ZERO;
      end else begin
         r_mole_idx <= r_mole_idx;
         r_poner    <= r_poner;
      end
   end

   // Score and miss counters; a hit outranks a simultaneous expiry.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_score  <= 8'd0;
         r_misses <= 8'd0;
      end else if (w_start_game) begin
         r_score  <= 8'd0;
         r_misses <= 8'd0;
      end else if ((r_state == S_UP) && w_hit) begin
         r_score  <= (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
         r_misses <= r_misses;
      end else if ((r_state == S_UP) && w_expire) begin
         r_score  <= r_score;
         r_misses <= r_misses + 8'd1;
      end else begin
         r_score  <= r_score;
         r_misses <= r_misses;
      end
   end

   // Game-over flag, registered alongside the state it mirrors.
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_game_over <= 1'b0;
      end else begin
         r_game_over <= (w_state_nxt == S_OVER);
      end
   end

   assign oPONER_TOPO = r_poner;
   assign oSELECT     = r_select;
   assign oGOLPE      = r_golpe;
   assign oSCORE      = r_score;
   assign oMISSES     = r_misses;
   assign oGAME_OVER  = r_game_over;

endmodule

// File: tb/tb_control_topos.sv
// -----------------------------------------------------------------------------
// tb_control_topos
// Directed bench for control_topos with a phase/age behavioural model that is
// compared against every output on each falling clock edge, plus literal
// expectations for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_control_topos;

   localparam int N        = 9;
   localparam int TD       = 4;
   localparam int MT       = 3;
   localparam int GT       = 2;
   localparam int MM       = 3;
   localparam int UP_CLKS  = MT * TD;
   localparam int GAP_CLKS = GT * TD;
   localparam int P_IDLE = 0, P_SPAWN = 1, P_UP = 2, P_GAP = 3, P_OVER = 4;

   logic         Clock = 1'b0;
   logic         reset = 1'b1;
   logic         iSTART = 1'b0;
   logic         iBTN_NEXT = 1'b0;
   logic         iBTN_PREV = 1'b0;
   logic         iBTN_HIT = 1'b0;
   logic [N-1:0] iHIT;
   logic [N-1:0] r_extra_hit = '0;
   logic [N-1:0] oPONER_TOPO;
   logic [N-1:0] oSELECT;
   logic         oGOLPE;
   logic [7:0]   oSCORE;
   logic [7:0]   oMISSES;
   logic         oGAME_OVER;

   int checks = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   // Bench cells: the mole cell that is both placed and selected answers a strike.
   assign iHIT = (oGOLPE ? (oPONER_TOPO & oSELECT) : '0) | r_extra_hit;

   control_topos #(
      .N_CELLS(N), .TICK_DIV(TD), .MOLE_TICKS(MT), .GAP_TICKS(GT), .MAX_MISSES(MM)
   ) dut (
      .Clock(Clock), .reset(reset), .iSTART(iSTART), .iBTN_NEXT(iBTN_NEXT),
      .iBTN_PREV(iBTN_PREV), .iBTN_HIT(iBTN_HIT), .iHIT(iHIT),
      .oPONER_TOPO(oPONER_TOPO), .oSELECT(oSELECT), .oGOLPE(oGOLPE),
      .oSCORE(oSCORE), .oMISSES(oMISSES), .oGAME_OVER(oGAME_OVER)
   );

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int pick(input logic [7:0] lf, input int prev);
      int c;
      c = int'(lf) % N;
      if (c == prev) c = (c + 1) % N;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_phase, m_age, m_cur, m_mole, m_score, m_miss;
   logic [7:0] m_lfsr;
   logic       m_golpe;

   always @(posedge Clock or posedge reset) begin
      if (reset) begin
         m_phase <= P_IDLE; m_age <= 0; m_cur <= 0; m_mole <= 0;
         m_score <= 0; m_miss <= 0; m_lfsr <= 8'hA5; m_golpe <= 1'b0;
      end else begin
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         if (iBTN_NEXT && !iBTN_PREV) m_cur <= (m_cur + 1) % N;
         else if (iBTN_PREV && !iBTN_NEXT) m_cur <= (m_cur + N - 1) % N;
         m_golpe <= iBTN_HIT && (m_phase == P_UP);
         m_age <= m_age + 1;
         case (m_phase)
            P_IDLE, P_OVER: if (iSTART) begin
               m_phase <= P_SPAWN; m_score <= 0; m_miss <= 0;
            end
            P_SPAWN: begin
               m_mole <= pick(m_lfsr, m_mole); m_phase <= P_UP; m_age <= 0;
            end
            P_UP: if (iHIT[m_mole]) begin
               m_score <= (m_score < 255) ? m_score + 1 : 255; m_phase <= P_GAP; m_age <= 0;
            end else if (m_age == UP_CLKS - 1) begin
               m_miss <= m_miss + 1; m_phase <= P_GAP; m_age <= 0;
            end
            P_GAP: if (m_age == GAP_CLKS - 1) begin
               m_phase <= (m_miss >= MM) ? P_OVER : P_SPAWN; m_age <= 0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge Clock) begin
      if (!reset) begin
         chk("m_poner",  32'(oPONER_TOPO), 32'((m_phase == P_UP) ? oh(m_mole) : '0));
         chk("m_select", 32'(oSELECT),     32'(oh(m_cur)));
         chk("m_golpe",  32'(oGOLPE),      32'(m_golpe));
         chk("m_score",  32'(oSCORE),      32'(m_score));
         chk("m_misses", 32'(oMISSES),     32'(m_miss));
         chk("m_over",   32'(oGAME_OVER),  32'(m_phase == P_OVER));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_next();
      iBTN_NEXT = 1'b1; @(posedge Clock); #1; iBTN_NEXT = 1'b0;
   endtask
   task automatic pulse_prev();
      iBTN_PREV = 1'b1; @(posedge Clock); #1; iBTN_PREV = 1'b0;
   endtask
   task automatic pulse_hit();
      iBTN_HIT = 1'b1; @(posedge Clock); #1; iBTN_HIT = 1'b0;
   endtask
   task automatic pulse_start();
      iSTART = 1'b1; @(posedge Clock); #1; iSTART = 1'b0;
   endtask

   task automatic wait_phase(input int ph, input int budget, input string nm);
      int n;
      n = 0;
      while (m_phase != ph && n < budget) begin
         @(posedge Clock); #1; n++;
      end
      if (m_phase != ph) begin
         checks++; failures++;
         $display("FAIL %s: timeout after %0d cycles, phase=%0d wanted=%0d", nm, n, m_phase, ph);
      end
   endtask

   task automatic move_to(input int target);
      int d;
      d = (target - m_cur + N) % N;
      if (d <= N / 2) repeat (d) pulse_next();
      else repeat (N - d) pulse_prev();
   endtask

   task automatic hit_mole(input int exp_score, input string nm);
      wait_phase(P_UP, 40, {nm, "_wait_up"});
      move_to(m_mole);
      pulse_hit();
      @(negedge Clock);
      chk({nm, "_golpe"}, 32'(oGOLPE), 32'd1);
      @(posedge Clock); #1;
      chk({nm, "_poner_clr"}, 32'(oPONER_TOPO), 32'd0);
      chk({nm, "_score"}, 32'(oSCORE), 32'(exp_score));
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      logic [N-1:0] prev_oh;
      int           up_len, gap_len, n;

      repeat (2) @(negedge Clock);
      #1 reset = 1'b0;
      @(posedge Clock); #1;

      // 1: cursor wrap and cancel
      chk("sel_reset", 32'(oSELECT), 32'h001);
      pulse_prev();
      chk("sel_prev_wrap", 32'(oSELECT), 32'h100);
      pulse_next();
      pulse_next();
      chk("sel_next_wrap", 32'(oSELECT), 32'h002);
      iBTN_NEXT = 1'b1; iBTN_PREV = 1'b1;
      @(posedge Clock); #1;
      iBTN_NEXT = 1'b0; iBTN_PREV = 1'b0;
      chk("sel_both", 32'(oSELECT), 32'h002);

      // 2: unattended mole timing
      pulse_start();
      n = 0;
      while (oPONER_TOPO == '0 && n < 20) begin @(negedge Clock); n++; end
      prev_oh = oPONER_TOPO;
      chk("first_mole_onehot", 32'($onehot(oPONER_TOPO)), 32'd1);
      up_len = 0;
      while (oPONER_TOPO == prev_oh && up_len < 40) begin up_len++; @(negedge Clock); end
      chk("up_len", 32'(up_len), 32'd12);
      gap_len = 0;
      while (oPONER_TOPO == '0 && gap_len < 40) begin gap_len++; @(negedge Clock); end
      // 8 GAP clocks plus the single SPAWN clock before the new mole shows.
      chk("dark_len", 32'(gap_len), 32'd9);
      chk("new_mole_differs", 32'((oPONER_TOPO != prev_oh) && $onehot(oPONER_TOPO)), 32'd1);
      chk("misses_1", 32'(oMISSES), 32'd1);

      // 3: successful strike
      hit_mole(1, "hit1");
      chk("hit1_misses", 32'(oMISSES), 32'd1);

      // 4: strike in GAP, strike off the mole, stray return from another cell
      pulse_hit();
      @(negedge Clock);
      chk("golpe_in_gap", 32'(oGOLPE), 32'd0);
      wait_phase(P_UP, 40, "off_wait_up");
      move_to((m_mole + 1) % N);
      pulse_hit();
      @(negedge Clock);
      chk("golpe_off_mole", 32'(oGOLPE), 32'd1);
      @(posedge Clock); #1;
      chk("mole_stays_off", 32'(oPONER_TOPO), 32'(oh(m_mole)));
      r_extra_hit = oh((m_mole + 2) % N);
      @(posedge Clock); #1;
      r_extra_hit = '0;
      chk("mole_stays_stray", 32'(oPONER_TOPO), 32'(oh(m_mole)));
      chk("score_unchanged", 32'(oSCORE), 32'd1);

      // 5: expire to game over, then restart
      wait_phase(P_GAP, 40, "exp2_wait");
      chk("misses_2", 32'(oMISSES), 32'd2);
      wait_phase(P_OVER, 80, "over_wait");
      @(negedge Clock);
      chk("over_flag", 32'(oGAME_OVER), 32'd1);
      chk("over_misses", 32'(oMISSES), 32'd3);
      chk("over_poner", 32'(oPONER_TOPO), 32'd0);
      pulse_hit();
      @(negedge Clock);
      chk("golpe_in_over", 32'(oGOLPE), 32'd0);
      pulse_start();
      chk("restart_over", 32'(oGAME_OVER), 32'd0);
      chk("restart_score", 32'(oSCORE), 32'd0);
      chk("restart_misses", 32'(oMISSES), 32'd0);
      @(posedge Clock); #1;
      chk("restart_mole", 32'($onehot(oPONER_TOPO)), 32'd1);

      // hit arriving on the expiry edge: the hit wins
      repeat (UP_CLKS - 1) @(posedge Clock);
      #1 r_extra_hit = oh(m_mole);
      @(posedge Clock); #1;
      r_extra_hit = '0;
      chk("tie_score", 32'(oSCORE), 32'd1);
      chk("tie_misses", 32'(oMISSES), 32'd0);
      chk("tie_poner", 32'(oPONER_TOPO), 32'd0);

      hit_mole(2, "hit2");

      // 6: asynchronous reset in UP
      wait_phase(P_UP, 40, "rst_wait_up");
      @(negedge Clock);
      #2 reset = 1'b1;
      #1;
      chk("rst_poner", 32'(oPONER_TOPO), 32'd0);
      chk("rst_select", 32'(oSELECT), 32'h001);
      chk("rst_golpe", 32'(oGOLPE), 32'd0);
      chk("rst_score", 32'(oSCORE), 32'd0);
      chk("rst_misses", 32'(oMISSES), 32'd0);
      chk("rst_over", 32'(oGAME_OVER), 32'd0);
      @(negedge Clock);
      #1 reset = 1'b0;
      repeat (10) @(posedge Clock);
      #1;
      chk("idle_no_mole", 32'(oPONER_TOPO), 32'd0);
      pulse_start();
      wait_phase(P_UP, 10, "resume_wait");
      @(negedge Clock);
      chk("resume_mole", 32'($onehot(oPONER_TOPO)), 32'd1);
      repeat (4) @(posedge Clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
